// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding,
// default bus widths and the AHB HTRANS encodings.
package apb_bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NSLV_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

endpackage

// File: rtl/apb_controller_if.sv
// Bus bundle between the AHB slave interface / APB peripherals and the
// APB controller. The controller uses the master modport.
interface apb_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) ();
  logic              valid;
  logic              hwrite;
  logic              hwritereg;
  logic [ADDR_W-1:0] haddr;
  logic [ADDR_W-1:0] haddr1;
  logic [ADDR_W-1:0] haddr2;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hwdata1;
  logic [NSLV-1:0]   temp_selx;

  logic              pwrite;
  logic              penable;
  logic [NSLV-1:0]   pselx;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hreadyout;

  modport master (
    input  valid, hwrite, hwritereg, haddr, haddr1, haddr2,
           hwdata, hwdata1, temp_selx,
    output pwrite, penable, pselx, paddr, pwdata, hreadyout
  );

  modport slave (
    output valid, hwrite, hwritereg, haddr, haddr1, haddr2,
           hwdata, hwdata1, temp_selx,
    input  pwrite, penable, pselx, paddr, pwdata, hreadyout
  );
endinterface

// File: rtl/apb_controller.sv
// APB-side master FSM of the AHB-to-APB bridge. Sequences SETUP/ENABLE
// phases for single reads, single writes and pipelined writes, and
// throttles the AHB master through hreadyout. All outputs are registered.
module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSLV   = NSLV_DEF
) (
  input  logic          hclk,
  input  logic          hresetn,
  apb_controller_if.master bus
);

  state_e            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hreadyout_q, hreadyout_d;

  // State register
  always_ff @(posedge hclk) begin
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid && bus.hwrite)       state_d = ST_WWAIT;
        else if (bus.valid)                state_d = ST_READ;
      end
      ST_WWAIT:    state_d = bus.valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_d = ST_RENABLE;
      ST_WRITE:    state_d = bus.valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_d = ST_WENABLEP;
      ST_RENABLE,
      ST_WENABLE: begin
        if (bus.valid && !bus.hwrite)      state_d = ST_READ;
        else if (bus.valid && bus.hwrite)  state_d = ST_WWAIT;
        else                               state_d = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!bus.hwritereg)                state_d = ST_READ;
        else if (bus.valid)                state_d = ST_WRITEP;
        else                               state_d = ST_WRITE;
      end
    endcase
  end

  // Next output values, keyed on the state being entered
  always_comb begin
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    pselx_d     = pselx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hreadyout_d = hreadyout_q;
    unique case (state_d)
      ST_IDLE: begin
        pselx_d     = '0;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        hreadyout_d = 1'b1;
      end
      ST_WWAIT: begin
        // Address captured; write data arrives on the next cycle.
        pselx_d     = '0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
      ST_READ: begin
        paddr_d     = bus.haddr;
        pwrite_d    = 1'b0;
        pselx_d     = bus.temp_selx;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ST_WRITE,
      ST_WRITEP: begin
        pwrite_d    = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        if (state_q == ST_WENABLEP) begin
          // Queued write of a pipelined pair: its address/data are one
          // stage older by now; select is unchanged from the first write.
          paddr_d  = bus.haddr2;
          pwdata_d = bus.hwdata1;
        end else begin
          paddr_d  = bus.haddr1;
          pwdata_d = bus.hwdata;
          pselx_d  = bus.temp_selx;
        end
      end
      ST_RENABLE,
      ST_WENABLE,
      ST_WENABLEP: begin
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
    endcase
  end

  // Registered APB outputs and AHB ready
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pselx_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hreadyout_q <= 1'b1;
    end else begin
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pselx_q     <= pselx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  assign bus.pwrite    = pwrite_q;
  assign bus.penable   = penable_q;
  assign bus.pselx     = pselx_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset, idle hold, single read,
// single write, pipelined writes, write-then-read, unmapped read and
// reset during ENABLE.
module tb_apb_controller;
  import apb_bridge_pkg::*;

  logic hclk = 1'b0;
  logic hresetn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic pen_prev = 1'b0;

  apb_controller_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; also flag penable high on consecutive cycles.
  task automatic step();
    @(posedge hclk);
    #1;
    chk("pen_b2b", {63'd0, pen_prev & bus.penable}, 64'd0);
    pen_prev = bus.penable;
  endtask

  task automatic chk_st(input string tag, input state_e exp);
    chk(tag, 64'(dut.state_q), 64'(exp));
  endtask

  task automatic drv_quiet();
    bus.valid = 1'b0; bus.hwrite = 1'b0; bus.hwritereg = 1'b0;
    bus.haddr = '0; bus.haddr1 = '0; bus.haddr2 = '0;
    bus.hwdata = '0; bus.hwdata1 = '0; bus.temp_selx = '0;
  endtask

  initial begin
    drv_quiet();
    hresetn = 1'b0;
    step(); step();
    hresetn = 1'b1;

    // Reset values
    chk_st("rst_state", ST_IDLE);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_pselx", 64'(bus.pselx), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_hready", 64'(bus.hreadyout), 64'd1);

    // Idle hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ctl", 64'({bus.pwrite, bus.penable, bus.pselx, bus.hreadyout}), 64'b000001);
      chk("idle_paddr", 64'(bus.paddr), 64'd0);
    end

    // Single read
    bus.valid = 1'b1; bus.hwrite = 1'b0; bus.haddr = 32'h8000_1000; bus.temp_selx = 3'b001;
    step();
    chk_st("rd_setup_st", ST_READ);
    chk("rd_setup_pselx", 64'(bus.pselx), 64'b001);
    chk("rd_setup_paddr", 64'(bus.paddr), 64'h8000_1000);
    chk("rd_setup_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rd_setup_pen", 64'(bus.penable), 64'd0);
    chk("rd_setup_hrdy", 64'(bus.hreadyout), 64'd0);
    drv_quiet();
    step();
    chk_st("rd_en_st", ST_RENABLE);
    chk("rd_en_pen", 64'(bus.penable), 64'd1);
    chk("rd_en_hrdy", 64'(bus.hreadyout), 64'd1);
    chk("rd_en_pselx", 64'(bus.pselx), 64'b001);
    step();
    chk_st("rd_idle_st", ST_IDLE);
    chk("rd_idle_pselx", 64'(bus.pselx), 64'd0);
    chk("rd_idle_pen", 64'(bus.penable), 64'd0);

    // Single write
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8400_0010; bus.temp_selx = 3'b010;
    step();
    chk_st("wr_wait_st", ST_WWAIT);
    chk("wr_wait_pselx", 64'(bus.pselx), 64'd0);
    chk("wr_wait_hrdy", 64'(bus.hreadyout), 64'd1);
    drv_quiet();
    bus.hwritereg = 1'b1; bus.haddr1 = 32'h8400_0010; bus.hwdata = 32'h526; bus.temp_selx = 3'b010;
    step();
    chk_st("wr_setup_st", ST_WRITE);
    chk("wr_setup_paddr", 64'(bus.paddr), 64'h8400_0010);
    chk("wr_setup_pwdata", 64'(bus.pwdata), 64'h526);
    chk("wr_setup_pwrite", 64'(bus.pwrite), 64'd1);
    chk("wr_setup_pselx", 64'(bus.pselx), 64'b010);
    chk("wr_setup_hrdy", 64'(bus.hreadyout), 64'd0);
    drv_quiet();
    step();
    chk_st("wr_en_st", ST_WENABLE);
    chk("wr_en_pen", 64'(bus.penable), 64'd1);
    chk("wr_en_pwrite", 64'(bus.pwrite), 64'd1);
    step();
    chk_st("wr_idle_st", ST_IDLE);
    chk("wr_idle_pwrite", 64'(bus.pwrite), 64'd0);
    chk("wr_idle_paddr_hold", 64'(bus.paddr), 64'h8400_0010);

    // Pipelined writes
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8000_0000; bus.temp_selx = 3'b001;
    step();
    chk_st("pw_wait_st", ST_WWAIT);
    bus.haddr = 32'h8000_0004; bus.haddr1 = 32'h8000_0000; bus.hwdata = 32'h11; bus.hwritereg = 1'b1;
    step();
    chk_st("pw_writep_st", ST_WRITEP);
    chk("pw1_paddr", 64'(bus.paddr), 64'h8000_0000);
    chk("pw1_pwdata", 64'(bus.pwdata), 64'h11);
    chk("pw1_pselx", 64'(bus.pselx), 64'b001);
    bus.valid = 1'b0; bus.haddr1 = 32'h8000_0004; bus.haddr2 = 32'h8000_0000;
    bus.hwdata = 32'h22; bus.hwdata1 = 32'h11; bus.temp_selx = 3'b000;
    step();
    chk_st("pw_wenp_st", ST_WENABLEP);
    chk("pw1_pen", 64'(bus.penable), 64'd1);
    bus.haddr2 = 32'h8000_0004; bus.hwdata1 = 32'h22;
    step();
    chk_st("pw_write_st", ST_WRITE);
    chk("pw2_paddr", 64'(bus.paddr), 64'h8000_0004);
    chk("pw2_pwdata", 64'(bus.pwdata), 64'h22);
    chk("pw2_pselx_held", 64'(bus.pselx), 64'b001);
    chk("pw2_pen", 64'(bus.penable), 64'd0);
    drv_quiet();
    step();
    chk_st("pw_wen_st", ST_WENABLE);
    chk("pw2_pen_en", 64'(bus.penable), 64'd1);
    step();
    chk_st("pw_idle_st", ST_IDLE);

    // Write then read via WENABLEP
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8000_0008; bus.temp_selx = 3'b001;
    step();
    bus.haddr1 = 32'h8000_0008; bus.hwdata = 32'h33; bus.hwritereg = 1'b1;
    bus.hwrite = 1'b0; bus.haddr = 32'h8800_0020; bus.temp_selx = 3'b100;
    step();
    chk_st("wtr_writep_st", ST_WRITEP);
    step();
    chk_st("wtr_wenp_st", ST_WENABLEP);
    bus.hwritereg = 1'b0;
    step();
    chk_st("wtr_read_st", ST_READ);
    chk("wtr_pselx", 64'(bus.pselx), 64'b100);
    chk("wtr_pwrite", 64'(bus.pwrite), 64'd0);
    chk("wtr_paddr", 64'(bus.paddr), 64'h8800_0020);
    drv_quiet();
    step();
    chk_st("wtr_ren_st", ST_RENABLE);
    step();

    // Unmapped read still sequences with pselx=0
    bus.valid = 1'b1; bus.hwrite = 1'b0; bus.haddr = 32'h9000_0000; bus.temp_selx = 3'b000;
    step();
    chk_st("unm_st", ST_READ);
    chk("unm_pselx", 64'(bus.pselx), 64'd0);
    drv_quiet();
    step();
    chk_st("unm_en_st", ST_RENABLE);
    step();

    // Reset during WENABLE, with valid asserted
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8400_0040; bus.temp_selx = 3'b010;
    step();
    drv_quiet();
    bus.haddr1 = 32'h8400_0040; bus.hwdata = 32'h77; bus.temp_selx = 3'b010;
    step();
    drv_quiet();
    step();
    chk_st("mr_pre_st", ST_WENABLE);
    hresetn = 1'b0;
    bus.valid = 1'b1; bus.hwrite = 1'b1;
    step();
    hresetn = 1'b1;
    drv_quiet();
    chk_st("mr_st", ST_IDLE);
    chk("mr_pen", 64'(bus.penable), 64'd0);
    chk("mr_pselx", 64'(bus.pselx), 64'd0);
    chk("mr_hrdy", 64'(bus.hreadyout), 64'd1);
    chk("mr_paddr", 64'(bus.paddr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
